// File: rtl/la_capture_pkg.sv
// Shared types and constants for the la_capture logic-analyser core.
//   state_e        : capture FSM state encoding (also driven on state_o)
//   TRIG_*         : trig_mode encodings; 2'b11 behaves as TRIG_FORCE
package la_capture_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StWait = 3'd2,
    StPost = 3'd3,
    StRead = 3'd4
  } state_e;

  localparam logic [1:0] TRIG_LEVEL  = 2'b00;
  localparam logic [1:0] TRIG_CHANGE = 2'b01;
  localparam logic [1:0] TRIG_FORCE  = 2'b10;

endpackage

// File: rtl/la_capture_if.sv
// Readout stream of the capture core (valid/ready, oldest sample first).
//   rd_data  : captured sample
//   rd_valid : rd_data valid
//   rd_last  : final (DEPTH-th) sample of the window
//   rd_ready : consumer accepts when rd_valid & rd_ready
// master = capture core, slave = consumer (UART TX path).
interface la_capture_if #(
  parameter int unsigned WIDTH = 21
);
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_last;
  logic             rd_ready;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/la_capture_ram.sv
// Simple dual-port capture buffer, WIDTH x DEPTH, one write port and one
// registered read port (1-cycle latency). No reset so it maps onto block RAM.
//   clk_i   : clock
//   we_i    : write enable      waddr_i / wdata_i : write address / data
//   re_i    : read enable       raddr_i           : read address
//   rdata_o : read data, valid the cycle after re_i
module la_capture_ram #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/la_capture.sv
// On-chip logic-analyser capture core. Samples probe_i (optionally decimated)
// into a DEPTH-entry ring buffer around a level/change/force trigger with a
// runtime pre-trigger depth, then streams the window oldest-first on rd.
//   clk, rst        : clock, asynchronous active-high reset
//   probe_i         : signals under test
//   arm, abort      : start capture (IDLE only) / return to IDLE (wins)
//   trig_mode/mask/value : live trigger configuration
//   pre_cnt, decim  : pre-trigger samples and decimation, latched on arm
//   state_o, triggered, done : status
//   rd              : readout stream (master side)
module la_capture
  import la_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DIV_W = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] probe_i,
  input  logic             arm,
  input  logic             abort,
  input  logic [1:0]       trig_mode,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [AW-1:0]    pre_cnt,
  input  logic [DIV_W-1:0] decim,
  output logic [2:0]       state_o,
  output logic             triggered,
  output logic             done,
  la_capture_if.master     rd
);
  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LastIss = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] OneW    = (AW+1)'(1);

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_addr_q, rd_addr_d, pre_q, pre_d;
  logic [AW:0]      fill_q, fill_d, iss_q, iss_d;
  logic [DIV_W-1:0] div_q, div_d, decim_q, decim_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             triggered_q, triggered_d, done_q, done_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic             out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic             skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic             infl_q, infl_d, infl_last_q, infl_last_d;

  logic             capturing, strobe, cond, trig_hit, re, pop;
  logic [AW:0]      post_target;
  logic [1:0]       occ_next;
  logic [WIDTH-1:0] ram_rdata;

  assign capturing   = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
  assign strobe      = capturing && (div_q == '0);
  assign post_target = DepthW - {1'b0, pre_q};
  assign pop         = out_vld_q && rd.rd_ready;

  // Change mode needs a real previous sample; prev_vld blocks the first strobe after arm.
  always_comb begin
    cond = 1'b1;
    case (trig_mode)
      TRIG_LEVEL:  cond = ((probe_i ^ trig_value) & trig_mask) == '0;
      TRIG_CHANGE: cond = prev_vld_q && (((probe_i ^ prev_q) & trig_mask) != '0);
      default:     cond = 1'b1;
    endcase
  end

  assign trig_hit = strobe && (state_q == StWait) && cond;

  // Occupancy of out+skid once this cycle's pop and in-flight read settle. A new
  // read is issued only if its data will have a slot when it lands.
  assign occ_next = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, infl_q} - {1'b0, pop};
  assign re       = (state_q == StRead) && (iss_q != DepthW) && (occ_next <= 2'd1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_addr_d   = rd_addr_q;
    pre_d       = pre_q;
    fill_d      = fill_q;
    iss_d       = iss_q;
    div_d       = div_q;
    decim_d     = decim_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    triggered_d = triggered_q;
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    infl_d      = 1'b0;
    infl_last_d = infl_last_q;

    if (capturing) begin
      div_d = (div_q == '0) ? decim_q : div_q - DIV_W'(1);
    end
    if (strobe) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      prev_d     = probe_i;
      prev_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          pre_d      = pre_cnt;
          decim_d    = decim;
          div_d      = decim;
          wr_ptr_d   = '0;
          fill_d     = '0;
          iss_d      = '0;
          prev_vld_d = 1'b0;
          state_d    = (pre_cnt == '0) ? StWait : StPre;
        end
      end
      StPre: begin
        if (strobe) begin
          fill_d = fill_q + OneW;
          if (fill_d == {1'b0, pre_q}) state_d = StWait;
        end
      end
      StWait: begin
        if (trig_hit) begin
          triggered_d = 1'b1;
          rd_addr_d   = wr_ptr_q - pre_q;
          fill_d      = OneW;  // trigger sample is post-sample 1
          state_d     = (post_target == OneW) ? StRead : StPost;
        end
      end
      StPost: begin
        if (strobe) begin
          fill_d = fill_q + OneW;
          if (fill_d == post_target) state_d = StRead;
        end
      end
      StRead: begin
        if (pop && out_last_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (re) begin
      iss_d       = iss_q + OneW;
      rd_addr_d   = rd_addr_q + AW'(1);
      infl_d      = 1'b1;
      infl_last_d = (iss_q == LastIss);
    end

    // Two-entry output queue: out register in front, skid behind it.
    if (pop) begin
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_vld_d = infl_q;
        if (infl_q) begin
          skid_data_d = ram_rdata;
          skid_last_d = infl_last_q;
        end
      end else if (infl_q) begin
        out_data_d = ram_rdata;
        out_last_d = infl_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (infl_q) begin
      if (!out_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = ram_rdata;
        out_last_d = infl_last_q;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = ram_rdata;
        skid_last_d = infl_last_q;
      end
    end

    if (abort) begin
      state_d    = StIdle;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
      skid_vld_d = 1'b0;
      infl_d     = 1'b0;
    end
    if (state_d == StIdle) triggered_d = 1'b0;
    done_d = (state_d == StRead);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      pre_q       <= '0;
      fill_q      <= '0;
      iss_q       <= '0;
      div_q       <= '0;
      decim_q     <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      pre_q       <= pre_d;
      fill_q      <= fill_d;
      iss_q       <= iss_d;
      div_q       <= div_d;
      decim_q     <= decim_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  la_capture_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (strobe),
    .waddr_i(wr_ptr_q),
    .wdata_i(probe_i),
    .re_i   (re),
    .raddr_i(rd_addr_q),
    .rdata_o(ram_rdata)
  );

  assign state_o     = state_q;
  assign triggered   = triggered_q;
  assign done        = done_q;
  assign rd.rd_data  = out_data_q;
  assign rd.rd_valid = out_vld_q;
  assign rd.rd_last  = out_last_q;
endmodule

// File: tb/tb_la_capture.sv
module tb_la_capture;
  import la_capture_pkg::*;

  localparam int unsigned W = 21;
  localparam int unsigned D = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   probe_i;
  logic           arm = 1'b0;
  logic           abort = 1'b0;
  logic [1:0]     trig_mode = 2'b00;
  logic [W-1:0]   trig_mask = '0;
  logic [W-1:0]   trig_value = '0;
  logic [3:0]     pre_cnt = '0;
  logic [15:0]    decim = '0;
  logic [2:0]     state_o;
  logic           triggered, done;
  logic           rd_ready = 1'b0;

  la_capture_if #(.WIDTH(W)) rif ();
  assign rif.rd_ready = rd_ready;

  la_capture #(
    .WIDTH(W),
    .DEPTH(D),
    .DIV_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .probe_i   (probe_i),
    .arm       (arm),
    .abort     (abort),
    .trig_mode (trig_mode),
    .trig_mask (trig_mask),
    .trig_value(trig_value),
    .pre_cnt   (pre_cnt),
    .decim     (decim),
    .state_o   (state_o),
    .triggered (triggered),
    .done      (done),
    .rd        (rif)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int arm_cyc = 0;
  int pmode = 0;
  int rel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // rel = 0 on the first cycle after arm, i.e. the first strobe when decim=0.
  always_comb begin
    rel = cyc - arm_cyc - 1;
    case (pmode)
      0:       probe_i = {rel[19:0], rel >= 9};
      1:       probe_i = {rel[18:0], rel >= 30, 1'b0};
      default: probe_i = rel[20:0];
    endcase
  end

  logic [W-1:0] got [D];
  logic [W-1:0] exp_v;
  int           n_beats, n_lasts, stall_err;
  bit           timed_out;
  logic         trig_seen, done_seen;

  task automatic do_arm(input int mode, input logic [3:0] pre, input logic [15:0] dv,
                        input logic [1:0] tm, input logic [W-1:0] mask,
                        input logic [W-1:0] val);
    @(posedge clk); #1;
    pmode = mode; pre_cnt = pre; decim = dv; trig_mode = tm;
    trig_mask = mask; trig_value = val; arm = 1'b1; arm_cyc = cyc;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // Gathers beats until the rd_last beat is presented with rd_ready high.
  task automatic collect(input bit rnd);
    logic [W-1:0] held;
    logic         held_last;
    bit           holding;
    n_beats = 0; n_lasts = 0; stall_err = 0; timed_out = 1'b1; holding = 1'b0;
    trig_seen = 1'b0; done_seen = 1'b0; held = '0; held_last = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding && (!rif.rd_valid || rif.rd_data !== held || rif.rd_last !== held_last))
        stall_err++;
      holding = 1'b0;
      if (rif.rd_valid) begin
        if (rd_ready) begin
          if (n_beats < D) got[n_beats] = rif.rd_data;
          n_beats++;
          if (rif.rd_last) begin
            n_lasts++;
            trig_seen = triggered;
            done_seen = done;
            timed_out = 1'b0;
            break;
          end
        end else begin
          holding = 1'b1; held = rif.rd_data; held_last = rif.rd_last;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state_o !== 3'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", state_o);
    end
    checks++;
    if ({triggered, done, rif.rd_valid, rif.rd_last} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {triggered, done, rif.rd_valid, rif.rd_last});
    end
    checks++;
    if (rif.rd_data !== '0) begin
      failures++; $display("FAIL reset_data got=%0h exp=0", rif.rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== StIdle) begin
      failures++; $display("FAIL reset_release_state got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_level();
    do_arm(0, 4'd4, 16'd0, TRIG_LEVEL, 21'h1, 21'h1);
    collect(1'b0);
    checks++;
    if (timed_out !== 1'b0 || n_beats != 16 || n_lasts != 1) begin
      failures++;
      $display("FAIL level_count got=%0d/%0d/%0d exp=0/16/1", timed_out, n_beats, n_lasts);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = {20'(5 + i), (5 + i) >= 9};
      checks++;
      if (got[i] !== exp_v) begin
        failures++; $display("FAIL level_data[%0d] got=%0h exp=%0h", i, got[i], exp_v);
      end
    end
    checks++;
    if ({trig_seen, done_seen} !== 2'b11) begin
      failures++; $display("FAIL level_status got=%b exp=11", {trig_seen, done_seen});
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== StIdle || {rif.rd_valid, done, triggered} !== 3'b000) begin
      failures++;
      $display("FAIL level_end got=%0d/%b exp=0/000", state_o, {rif.rd_valid, done, triggered});
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_change();
    do_arm(1, 4'd8, 16'd0, TRIG_CHANGE, 21'h2, 21'h0);
    collect(1'b0);
    checks++;
    if (timed_out !== 1'b0 || n_beats != 16 || n_lasts != 1) begin
      failures++;
      $display("FAIL change_count got=%0d/%0d/%0d exp=0/16/1", timed_out, n_beats, n_lasts);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = {19'(22 + i), (22 + i) >= 30, 1'b0};
      checks++;
      if (got[i] !== exp_v) begin
        failures++; $display("FAIL change_data[%0d] got=%0h exp=%0h", i, got[i], exp_v);
      end
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic test_decim_force();
    do_arm(2, 4'd0, 16'd3, TRIG_FORCE, 21'h0, 21'h0);
    collect(1'b0);
    checks++;
    if (timed_out !== 1'b0 || n_beats != 16 || n_lasts != 1) begin
      failures++;
      $display("FAIL decim_count got=%0d/%0d/%0d exp=0/16/1", timed_out, n_beats, n_lasts);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = 21'(3 + 4 * i);
      checks++;
      if (got[i] !== exp_v) begin
        failures++; $display("FAIL decim_data[%0d] got=%0h exp=%0h", i, got[i], exp_v);
      end
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic test_random_ready();
    do_arm(2, 4'd0, 16'd0, 2'b11, 21'h0, 21'h0);
    collect(1'b1);
    checks++;
    if (timed_out !== 1'b0 || n_beats != 16 || n_lasts != 1) begin
      failures++;
      $display("FAIL rand_count got=%0d/%0d/%0d exp=0/16/1", timed_out, n_beats, n_lasts);
    end
    checks++;
    if (stall_err != 0) begin
      failures++; $display("FAIL rand_stall got=%0d exp=0", stall_err);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = 21'(i);
      checks++;
      if (got[i] !== exp_v) begin
        failures++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, got[i], exp_v);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== StIdle || rif.rd_valid !== 1'b0) begin
      failures++; $display("FAIL rand_end got=%0d/%b exp=0/0", state_o, rif.rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_arm(2, 4'd0, 16'd0, TRIG_FORCE, 21'h0, 21'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state_o !== StPost || triggered !== 1'b1) begin
      failures++; $display("FAIL abort_pre got=%0d/%b exp=3/1", state_o, triggered);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (state_o !== StIdle || {triggered, done, rif.rd_valid, rif.rd_last} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_idle got=%0d/%b exp=0/0000", state_o,
               {triggered, done, rif.rd_valid, rif.rd_last});
    end
    arm = 1'b1; abort = 1'b1; pre_cnt = 4'd4;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    checks++;
    if (state_o !== StIdle) begin
      failures++; $display("FAIL abort_wins got=%0d exp=0", state_o);
    end
    do_arm(0, 4'd4, 16'd0, TRIG_LEVEL, 21'h1, 21'h1);
    collect(1'b0);
    checks++;
    if (timed_out !== 1'b0 || n_beats != 16 || n_lasts != 1) begin
      failures++;
      $display("FAIL rearm_count got=%0d/%0d/%0d exp=0/16/1", timed_out, n_beats, n_lasts);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = {20'(5 + i), (5 + i) >= 9};
      checks++;
      if (got[i] !== exp_v) begin
        failures++; $display("FAIL rearm_data[%0d] got=%0h exp=%0h", i, got[i], exp_v);
      end
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic test_arm_ignored();
    do_arm(2, 4'd0, 16'd0, TRIG_FORCE, 21'h0, 21'h0);
    repeat (3) @(posedge clk);
    #1;
    arm = 1'b1; pre_cnt = 4'd7; decim = 16'd5;
    @(posedge clk); #1;
    arm = 1'b0;
    checks++;
    if (state_o !== StPost) begin
      failures++; $display("FAIL armpost_state got=%0d exp=3", state_o);
    end
    collect(1'b0);
    checks++;
    if (timed_out !== 1'b0 || n_beats != 16 || n_lasts != 1) begin
      failures++;
      $display("FAIL armpost_count got=%0d/%0d/%0d exp=0/16/1", timed_out, n_beats, n_lasts);
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = 21'(i);
      checks++;
      if (got[i] !== exp_v) begin
        failures++; $display("FAIL armpost_data[%0d] got=%0h exp=%0h", i, got[i], exp_v);
      end
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    rd_ready = 1'b0;
    do_arm(2, 4'd0, 16'd0, TRIG_FORCE, 21'h0, 21'h0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (rif.rd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1 || done !== 1'b1 || triggered !== 1'b1) begin
      failures++; $display("FAIL arst_setup got=%b%b%b exp=111", seen, done, triggered);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (state_o !== StIdle || {rif.rd_valid, done, triggered, rif.rd_last} !== 4'b0000) begin
      failures++;
      $display("FAIL arst_drop got=%0d/%b exp=0/0000", state_o,
               {rif.rd_valid, done, triggered, rif.rd_last});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== StIdle || rif.rd_valid !== 1'b0) begin
      failures++; $display("FAIL arst_after got=%0d/%b exp=0/0", state_o, rif.rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_change();
    test_decim_force();
    test_random_ready();
    test_abort();
    test_arm_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
